// File: rtl/emergency_alert_pkg.sv
// rtl/emergency_alert_pkg.sv - shared state types and alarm_mode encodings for the alert sequencer
package emergency_alert_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WARN     = 3'd1,
        EVAC     = 3'd2,
        LOCK     = 3'd3,
        CLEARING = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_REQ  = 2'd1,
        D_DONE = 2'd2,
        D_FAIL = 2'd3
    } dispatch_t;

    localparam logic [1:0] ALARM_IDLE = 2'd0;
    localparam logic [1:0] ALARM_WARN = 2'd1;
    localparam logic [1:0] ALARM_EVAC = 2'd2;
    localparam logic [1:0] ALARM_LOCK = 2'd3;

    // CLEARING reports idle so the panel drops the mode as soon as release starts
    function automatic logic [1:0] modeToAlarm(input mode_t m);
        case (m)
            WARN:    return ALARM_WARN;
            EVAC:    return ALARM_EVAC;
            LOCK:    return ALARM_LOCK;
            default: return ALARM_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/emergency_dispatch_handshake.sv
// rtl/emergency_dispatch_handshake.sv - authority dispatch request/ack handshake with timeout and retry
module emergency_dispatch_handshake
    import emergency_alert_pkg::*;
#(
    parameter int ACK_TIMEOUT = 32,
    parameter int MAX_RETRY   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic startPulse,
    input  logic relPulse,
    input  logic dispatchAck,
    output logic dispatchReq,
    output logic dispatchFail
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam int RW = $clog2(MAX_RETRY) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    dispatch_t       dState;
    dispatch_t       dNext;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retryCnt;
    logic            gap;
    logic            failSticky;
    logic            timeoutHit;
    logic            retriesSpent;

    // an ack in the timeout cycle wins, so the timeout only fires without one
    assign timeoutHit   = (dState == D_REQ) && !gap && (timer == TIMER_LAST) && !dispatchAck;
    assign retriesSpent = (retryCnt == RETRY_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dState <= D_IDLE;
        end else begin
            dState <= dNext;
        end
    end

    always_comb begin
        dNext = dState;
        unique case (dState)
            D_IDLE: if (startPulse) dNext = D_REQ;
            D_REQ: begin
                if (dispatchAck) begin
                    dNext = D_DONE;
                end else if (timeoutHit && retriesSpent) begin
                    dNext = D_FAIL;
                end
            end
            D_DONE: if (relPulse) dNext = D_IDLE;
            D_FAIL: if (relPulse) dNext = D_IDLE;
            default: dNext = D_IDLE;
        endcase
    end

    // gap marks the single low cycle between a timed-out attempt and its retry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            retryCnt <= '0;
            gap      <= 1'b0;
        end else if (dState != D_REQ) begin
            timer    <= '0;
            retryCnt <= '0;
            gap      <= 1'b0;
        end else if (gap) begin
            timer <= '0;
            gap   <= 1'b0;
        end else if (timeoutHit) begin
            timer <= '0;
            gap   <= !retriesSpent;
            if (!retriesSpent) begin
                retryCnt <= retryCnt + 1'b1;
            end
        end else if (timer != TIMER_LAST) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            failSticky <= 1'b0;
        end else if (dState == D_REQ && dNext == D_FAIL) begin
            failSticky <= 1'b1;
        end
    end

    always_comb begin
        dispatchReq  = (dState == D_REQ) && !gap;
        dispatchFail = failSticky;
    end

endmodule

// File: rtl/emergency_alert_sequencer.sv
// rtl/emergency_alert_sequencer.sv - latches alarm mode, drives siren/strobe/PA cadence and dispatch link
// Optional build macro ALERT_TEST_MUTE_EN silences siren, PA and chime while is_system_test is high.
module emergency_alert_sequencer
    import emergency_alert_pkg::*;
#(
    parameter int EVAC_PERIOD = 16,
    parameter int LOCK_PERIOD = 4,
    parameter int CLEAR_HOLD  = 8,
    parameter int ACK_TIMEOUT = 32,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       warn_students,
    input  logic       need_evacuation,
    input  logic       lockdown_needed,
    input  logic       authority_contacted,
    input  logic       all_clear,
    input  logic       is_system_test,
    input  logic       dispatch_ack,
    output logic       siren,
    output logic       strobe,
    output logic       pa_lockdown,
    output logic       chime,
    output logic       dispatch_req,
    output logic       dispatch_fail,
    output logic [1:0] alarm_mode
);

    localparam int CAD_MAX = (EVAC_PERIOD > LOCK_PERIOD) ? EVAC_PERIOD : LOCK_PERIOD;
    localparam int CW      = $clog2(CAD_MAX) + 1;
    localparam int HW      = $clog2(CLEAR_HOLD) + 1;
    localparam logic [CW-1:0] EVAC_LAST = CW'(EVAC_PERIOD - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLEAR_HOLD - 1);

    mode_t         modeState;
    mode_t         modeNext;
    logic [CW-1:0] cadCnt;
    logic [CW-1:0] periodLast;
    logic          sirenPhase;
    logic [HW-1:0] holdCnt;
    logic          chimeFlag;
    logic          acPrev;
    logic          alarmIn;
    logic          clearTick;
    logic          holdDone;
    logic          latched;
    logic          entering;
    logic          startPulse;
    logic          relPulse;
    logic          muteOut;
    logic          sirenRaw;
    logic          paRaw;
    logic          chimeRaw;

    // any live alarm input vetoes the all-clear run
    assign alarmIn   = warn_students | need_evacuation | lockdown_needed;
    assign clearTick = all_clear & ~alarmIn;
    assign holdDone  = clearTick && (holdCnt == HOLD_LAST);
    assign latched   = (modeState == WARN) || (modeState == EVAC) || (modeState == LOCK);
    assign entering  = (modeNext != modeState) &&
                       ((modeNext == WARN) || (modeNext == EVAC) || (modeNext == LOCK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modeState <= IDLE;
        end else begin
            modeState <= modeNext;
        end
    end

    always_comb begin
        modeNext = modeState;
        unique case (modeState)
            IDLE: begin
                if (lockdown_needed)      modeNext = LOCK;
                else if (need_evacuation) modeNext = EVAC;
                else if (warn_students)   modeNext = WARN;
            end
            WARN: begin
                if (lockdown_needed)      modeNext = LOCK;
                else if (need_evacuation) modeNext = EVAC;
                else if (holdDone)        modeNext = CLEARING;
            end
            EVAC: begin
                if (lockdown_needed)      modeNext = LOCK;
                else if (holdDone)        modeNext = CLEARING;
            end
            LOCK:     if (holdDone) modeNext = CLEARING;
            CLEARING: modeNext = IDLE;
            default:  modeNext = IDLE;
        endcase
    end

    assign periodLast = (modeState == LOCK) ? LOCK_LAST : EVAC_LAST;

    // the siren phase restarts high on every escalation so each cadence begins audibly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cadCnt     <= '0;
            sirenPhase <= 1'b0;
        end else if (entering) begin
            cadCnt     <= '0;
            sirenPhase <= 1'b1;
        end else if (modeState == EVAC || modeState == LOCK) begin
            if (cadCnt == periodLast) begin
                cadCnt     <= '0;
                sirenPhase <= ~sirenPhase;
            end else begin
                cadCnt <= cadCnt + 1'b1;
            end
        end else begin
            cadCnt     <= '0;
            sirenPhase <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdCnt <= '0;
        end else if (latched && clearTick && !holdDone) begin
            holdCnt <= holdCnt + 1'b1;
        end else begin
            holdCnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chimeFlag <= 1'b0;
            acPrev    <= 1'b0;
        end else begin
            chimeFlag <= (modeState == IDLE) && (modeNext == WARN);
            acPrev    <= authority_contacted;
        end
    end

    always_comb begin
        sirenRaw   = 1'b0;
        strobe     = 1'b0;
        paRaw      = 1'b0;
        chimeRaw   = 1'b0;
        alarm_mode = modeToAlarm(modeState);
        case (modeState)
            WARN: begin
                strobe   = 1'b1;
                chimeRaw = chimeFlag;
            end
            EVAC: begin
                strobe   = 1'b1;
                sirenRaw = sirenPhase;
            end
            LOCK: begin
                strobe   = 1'b1;
                sirenRaw = sirenPhase;
                paRaw    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ALERT_TEST_MUTE_EN
    assign muteOut = is_system_test;
`else
    assign muteOut = 1'b0;
`endif

    assign siren       = sirenRaw & ~muteOut;
    assign pa_lockdown = paRaw & ~muteOut;
    assign chime       = chimeRaw & ~muteOut;

    assign startPulse = authority_contacted & ~acPrev & ~is_system_test;
    assign relPulse   = (modeState == CLEARING);

    emergency_dispatch_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) u_dispatch (
        .clk          (clk),
        .reset        (reset),
        .startPulse   (startPulse),
        .relPulse     (relPulse),
        .dispatchAck  (dispatch_ack),
        .dispatchReq  (dispatch_req),
        .dispatchFail (dispatch_fail)
    );

endmodule

// File: tb/tb_emergency_alert_sequencer.sv
// tb/tb_emergency_alert_sequencer.sv - directed and randomized checks of emergency_alert_sequencer against a cycle-level reference model
module tb_emergency_alert_sequencer;

    localparam int EVAC_P = 16;
    localparam int LOCK_P = 4;
    localparam int HOLD   = 8;
    localparam int TMO    = 32;
    localparam int RETRY  = 3;
`ifdef ALERT_TEST_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       warn_students, need_evacuation, lockdown_needed;
    logic       authority_contacted, all_clear, is_system_test, dispatch_ack;
    logic       siren, strobe, pa_lockdown, chime, dispatch_req, dispatch_fail;
    logic [1:0] alarm_mode;

    emergency_alert_sequencer #(
        .EVAC_PERIOD (EVAC_P),
        .LOCK_PERIOD (LOCK_P),
        .CLEAR_HOLD  (HOLD),
        .ACK_TIMEOUT (TMO),
        .MAX_RETRY   (RETRY)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .warn_students       (warn_students),
        .need_evacuation     (need_evacuation),
        .lockdown_needed     (lockdown_needed),
        .authority_contacted (authority_contacted),
        .all_clear           (all_clear),
        .is_system_test      (is_system_test),
        .dispatch_ack        (dispatch_ack),
        .siren               (siren),
        .strobe              (strobe),
        .pa_lockdown         (pa_lockdown),
        .chime               (chime),
        .dispatch_req        (dispatch_req),
        .dispatch_fail       (dispatch_fail),
        .alarm_mode          (alarm_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: level 0 idle, 1 warn, 2 evac, 3 lock, 4 clearing; phase 0 idle, 1 requesting, 2 done, 3 failed
    int cyc, mLevel, mEntry, mRun, dPhase, dStart;
    bit mChime, mFail, mAcPrev;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        cyc = 0; mLevel = 0; mEntry = 0; mRun = 0; dPhase = 0; dStart = 0;
        mChime = 0; mFail = 0; mAcPrev = 0;
    endtask

    task automatic modelEdge();
        int reqLvl, newLvl, off;
        bit alarmIn, rel, start;
        alarmIn = warn_students | need_evacuation | lockdown_needed;
        reqLvl  = lockdown_needed ? 3 : need_evacuation ? 2 : warn_students ? 1 : 0;
        rel     = (mLevel == 4);
        newLvl  = mLevel;
        if (mLevel == 4) newLvl = 0;
        else if (mLevel == 0) newLvl = reqLvl;
        else if (reqLvl > mLevel) newLvl = reqLvl;
        else if (all_clear && !alarmIn && mRun + 1 == HOLD) newLvl = 4;
        if (newLvl == mLevel && mLevel >= 1 && mLevel <= 3 && all_clear && !alarmIn) mRun++;
        else mRun = 0;
        mChime = (mLevel == 0 && newLvl == 1);
        if (newLvl != mLevel && newLvl >= 1 && newLvl <= 3) mEntry = cyc + 1;
        start = authority_contacted && !mAcPrev && !is_system_test;
        if (dPhase == 0) begin
            if (start) begin dPhase = 1; dStart = cyc + 1; end
        end else if (dPhase == 1) begin
            off = cyc - dStart;
            if (dispatch_ack) dPhase = 2;
            else if (off == RETRY * (TMO + 1) + TMO - 1) begin dPhase = 3; mFail = 1; end
        end else if (rel) begin
            dPhase = 0;
        end
        mAcPrev = authority_contacted;
        mLevel  = newLvl;
        cyc++;
    endtask

    task automatic checkAll();
        bit muted, lvlOn, sirenExp, reqExp;
        int per;
        muted    = MUTE_EN && is_system_test;
        lvlOn    = (mLevel >= 1 && mLevel <= 3);
        per      = (mLevel == 3) ? LOCK_P : EVAC_P;
        sirenExp = (mLevel == 2 || mLevel == 3) && (((cyc - mEntry) / per) % 2 == 0) && !muted;
        reqExp   = (dPhase == 1) && (((cyc - dStart) % (TMO + 1)) != TMO);
        check2("m_alarm_mode", alarm_mode, lvlOn ? 2'(mLevel) : 2'd0);
        check1("m_strobe", strobe, lvlOn);
        check1("m_siren", siren, sirenExp);
        check1("m_pa", pa_lockdown, (mLevel == 3) && !muted);
        check1("m_chime", chime, mChime && !muted);
        check1("m_req", dispatch_req, reqExp);
        check1("m_fail", dispatch_fail, mFail);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic clearInputs();
        warn_students = 0; need_evacuation = 0; lockdown_needed = 0;
        authority_contacted = 0; all_clear = 0; is_system_test = 0; dispatch_ack = 0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        modelReset();
        checkAll();
    endtask

    initial begin
        // reset state
        doReset();
        check2("rst_mode", alarm_mode, 2'd0);
        check1("rst_req", dispatch_req, 1'b0);

        // evacuation cadence: 16 high, 16 low, then asynchronous reset mid-cycle
        need_evacuation = 1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            need_evacuation = 0;
            if (i == 1) begin
                check2("evac_mode", alarm_mode, 2'd2);
                check1("evac_strobe", strobe, 1'b1);
            end
            check1("evac_siren", siren, i <= 16);
        end
        #2 reset = 1;
        #1;
        check2("async_mode", alarm_mode, 2'd0);
        check1("async_strobe", strobe, 1'b0);
        check1("async_siren", siren, 1'b0);
        check1("async_pa", pa_lockdown, 1'b0);
        check1("async_chime", chime, 1'b0);
        doReset();

        // warn with chime, escalate to lockdown three cycles later
        warn_students = 1;
        tick();
        warn_students = 0;
        check2("warn_mode", alarm_mode, 2'd1);
        check1("warn_chime", chime, 1'b1);
        check1("warn_siren", siren, 1'b0);
        tick();
        check1("warn_chime_end", chime, 1'b0);
        tick();
        lockdown_needed = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            lockdown_needed = 0;
            if (i == 1) begin
                check2("lock_mode", alarm_mode, 2'd3);
                check1("lock_pa", pa_lockdown, 1'b1);
            end
            check1("lock_siren", siren, ((i - 1) / 4) % 2 == 0);
        end

        // all-clear hold: 7 high, 1 low, 8 high
        doReset();
        need_evacuation = 1;
        tick();
        need_evacuation = 0;
        all_clear = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check2("clr7_mode", alarm_mode, 2'd2);
        end
        all_clear = 0;
        tick();
        all_clear = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check2("clr8_mode", alarm_mode, (i < 8) ? 2'd2 : 2'd0);
            check1("clr8_strobe", strobe, i < 8);
        end
        check1("clearing_siren", siren, 1'b0);
        all_clear = 0;
        tick();
        check2("idle_after_clear", alarm_mode, 2'd0);

        // dispatch acknowledged in the 10th request cycle
        doReset();
        authority_contacted = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check1("ack_req_hi", dispatch_req, 1'b1);
            if (i == 10) dispatch_ack = 1;
        end
        tick();
        dispatch_ack = 0;
        for (int i = 0; i < 3; i++) begin
            check1("ack_req_lo", dispatch_req, 1'b0);
            check1("ack_fail", dispatch_fail, 1'b0);
            tick();
        end
        authority_contacted = 0;

        // dispatch never acknowledged: 4 attempts, 1-cycle gaps, then sticky fail
        doReset();
        authority_contacted = 1;
        for (int i = 1; i <= 140; i++) begin
            int off;
            tick();
            off = i - 1;
            check1("retry_req", dispatch_req, (off / 33 < 4) && (off % 33 != 32));
            check1("retry_fail", dispatch_fail, off >= 131);
        end
        warn_students = 1;
        tick();
        warn_students = 0;
        all_clear = 1;
        repeat (9) tick();
        all_clear = 0;
        tick();
        check1("fail_sticky", dispatch_fail, 1'b1);
        check1("fail_req_lo", dispatch_req, 1'b0);
        authority_contacted = 0;
        tick();

        // system test: no dispatch; lights always, sound only when not muted
        doReset();
        is_system_test = 1;
        lockdown_needed = 1;
        authority_contacted = 1;
        tick();
        check2("test_mode", alarm_mode, 2'd3);
        check1("test_strobe", strobe, 1'b1);
        check1("test_siren", siren, !MUTE_EN);
        check1("test_pa", pa_lockdown, !MUTE_EN);
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("test_no_req", dispatch_req, 1'b0);
        end

        // randomized traffic against the model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            warn_students   = ($urandom_range(59) == 0);
            need_evacuation = ($urandom_range(79) == 0);
            lockdown_needed = ($urandom_range(119) == 0);
            all_clear       = ($urandom_range(9) < 8);
            dispatch_ack    = ($urandom_range(24) == 0);
            if ($urandom_range(49) == 0) authority_contacted = !authority_contacted;
            if ($urandom_range(199) == 0) is_system_test = !is_system_test;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
